sample_recorder: RTL and testbench

Capture block for the pad sampler: records a stream of 16-bit audio samples into a pad's sample RAM. It is the writer side of the RAM interface that the playback path reads. While the pad's record input is held, each accepted sample is written to consecutive addresses starting at 0. On completion the block publishes the recorded `depth`, which feeds the pad's playback address generator.

---
 rtl/sample_recorder_if.sv | 26 ++
 rtl/sample_recorder.sv | 119 +++++++++++
 tb/tb_sample_recorder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sample_recorder_if.sv
// Bundle between the pad's ADC front end / record button and the sample RAM writer.
// sampleValid is a one-cycle strobe with no backpressure; wren is a one-cycle write command.
interface sample_recorder_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              record;
    logic              sampleValid;
    logic [DATA_W-1:0] sampleIn;
    logic [ADDR_W-1:0] wrAddress;
    logic [DATA_W-1:0] wrData;
    logic              wren;
    logic [ADDR_W-1:0] depth;
    logic              recording;
    logic              done;

    modport master (
        input  record, sampleValid, sampleIn,
        output wrAddress, wrData, wren, depth, recording, done
    );

    modport slave (
        output record, sampleValid, sampleIn,
        input  wrAddress, wrData, wren, depth, recording, done
    );
endinterface

// File: rtl/sample_recorder.sv
// Records a gated stream of audio samples into a pad's sample RAM and publishes
// the last written address as the playback depth once a take completes.
module sample_recorder #(
    parameter int                ADDR_W   = 15,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}},
    parameter logic [DATA_W-1:0] THRESH   = DATA_W'(1024)
) (
    input  logic                    clock,
    input  logic                    reset,
    sample_recorder_if.master       bus,
    output logic [1:0]              state_dbg
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] RECORD = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W:0]   MAG_ONE  = {{DATA_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic              rec_q;
    logic [ADDR_W-1:0] cnt;
    logic              rise;
    logic [DATA_W:0]   ext;
    logic [DATA_W:0]   mag;
    logic              above;

    assign state_dbg = state;
    assign rise      = bus.record & ~rec_q;

    // One extra bit so that the most negative sample has a representable magnitude.
    always_comb begin
        ext   = {bus.sampleIn[DATA_W-1], bus.sampleIn};
        mag   = ext[DATA_W] ? (~ext + MAG_ONE) : ext;
        above = (mag >= {1'b0, THRESH});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            rec_q         <= 1'b0;
            cnt           <= '0;
            bus.wrAddress <= '0;
            bus.wrData    <= '0;
            bus.wren      <= 1'b0;
            bus.depth     <= '0;
            bus.recording <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            rec_q    <= bus.record;
            bus.wren <= 1'b0;
            bus.done <= 1'b0;
            // Lags the state by a cycle so it drops exactly when done rises.
            bus.recording <= (state == ARMED) || (state == RECORD);

            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt   <= '0;
                        state <= ARMED;
                    end
                end

                ARMED: begin
                    if (!bus.record) begin
                        state <= IDLE;
                    end else if (bus.sampleValid && above) begin
                        bus.wren      <= 1'b1;
                        bus.wrAddress <= '0;
                        bus.wrData    <= bus.sampleIn;
                        if (MAX_ADDR == '0) begin
                            state <= DONE;
                        end else begin
                            cnt   <= ADDR_ONE;
                            state <= RECORD;
                        end
                    end
                end

                RECORD: begin
                    if (!bus.record) begin
                        state <= DONE;
                    end else if (bus.sampleValid) begin
                        bus.wren      <= 1'b1;
                        bus.wrAddress <= cnt;
                        bus.wrData    <= bus.sampleIn;
                        if (cnt == MAX_ADDR) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt + ADDR_ONE;
                        end
                    end
                end

                DONE: begin
                    // wrAddress only moves on a write, so it still holds the last one.
                    bus.depth <= bus.wrAddress;
                    bus.done  <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    a_wren_while_recording: assert property (
        @(posedge clock) disable iff (reset) bus.wren |-> bus.recording);
    a_done_ends_recording: assert property (
        @(posedge clock) disable iff (reset) bus.done |-> !bus.recording);
    a_done_single_cycle: assert property (
        @(posedge clock) disable iff (reset) bus.done |=> !bus.done);
    a_cnt_bounded: assert property (
        @(posedge clock) disable iff (reset) cnt <= MAX_ADDR);
    a_addr_bounded: assert property (
        @(posedge clock) disable iff (reset) bus.wrAddress <= MAX_ADDR);
endmodule

// File: tb/tb_sample_recorder.sv
// Bench for sample_recorder: directed takes plus randomized takes, with expected
// RAM writes and done events queued at drive time and checked by a monitor.
module tb_sample_recorder;
    localparam int                ADDR_W   = 15;
    localparam int                DATA_W   = 16;
    localparam logic [ADDR_W-1:0] MAX_ADDR = 15'd7;
    localparam int                THRESH   = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  state_dbg;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_wr_q[$];
    logic [63:0] exp_done_q[$];
    logic [ADDR_W-1:0] model_depth;
    int          stim[$];

    sample_recorder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sample_recorder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ADDR(MAX_ADDR), .THRESH(16'd1024)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus.master), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input int c, input int addr, input int s);
        exp_wr_q.push_back({1'b0, 32'(c), ADDR_W'(addr), DATA_W'(s)});
    endtask

    task automatic push_done(input int c, input int d);
        exp_done_q.push_back({17'b0, 32'(c), ADDR_W'(d)});
        model_depth = ADDR_W'(d);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (bus.wren === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0h, want no write (cycle %0d)",
                         bus.wrAddress, bus.wrData, cyc);
            end else begin
                check("write{cyc,addr,data}", {1'b0, 32'(cyc), bus.wrAddress, bus.wrData},
                      exp_wr_q.pop_front());
            end
        end
        if (bus.done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done depth %0d, want no done (cycle %0d)",
                         bus.depth, cyc);
            end else begin
                check("done{cyc,depth}", {17'b0, 32'(cyc), bus.depth}, exp_done_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int mag(input int s);
        return (s < 0) ? -s : s;
    endfunction

    function automatic int rand_big();
        int m;
        m = int'($urandom_range(THRESH, 32767));
        if ($urandom_range(0, 9) == 0) return -32768;
        return ($urandom_range(0, 1) == 1) ? m : -m;
    endfunction

    function automatic int rand_small();
        int m;
        m = int'($urandom_range(0, THRESH - 1));
        return ($urandom_range(0, 1) == 1) ? m : -m;
    endfunction

    // Model of a take: writing begins at the first sample whose magnitude reaches
    // the gate, continues on every later sample, and stops after address MAX_ADDR.
    task automatic take(input string name, input int max_gap, input bit stop_with_last);
        bit started = 1'b0;
        bit full    = 1'b0;
        int cnt     = 0;
        bit last_stop;
        bus.record = 1'b1;
        step();
        for (int i = 0; i < stim.size(); i++) begin
            last_stop       = stop_with_last && (i == stim.size() - 1);
            bus.sampleValid = 1'b1;
            bus.sampleIn    = DATA_W'(stim[i]);
            if (last_stop) begin
                bus.record = 1'b0;
                if (started && !full) push_done(cyc + 2, cnt - 1);
            end else if (!full) begin
                if (!started && mag(stim[i]) >= THRESH) started = 1'b1;
                if (started) begin
                    push_wr(cyc + 1, cnt, stim[i]);
                    if (cnt == int'(MAX_ADDR)) begin
                        full = 1'b1;
                        push_done(cyc + 2, cnt);
                    end
                    cnt++;
                end
            end
            step();
            bus.sampleValid = 1'b0;
            repeat ($urandom_range(0, max_gap)) step();
        end
        if (!stop_with_last) begin
            bus.record = 1'b0;
            if (started && !full) push_done(cyc + 2, cnt - 1);
            step();
        end
        repeat (4) step();
        check({name, ".drained"}, 64'(exp_wr_q.size() + exp_done_q.size()), 64'd0);
        check({name, ".depth"}, 64'(bus.depth), 64'(model_depth));
        check({name, ".recording"}, 64'(bus.recording), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".wren"}, 64'(bus.wren), 64'd0);
        check({name, ".wrAddress"}, 64'(bus.wrAddress), 64'd0);
        check({name, ".wrData"}, 64'(bus.wrData), 64'd0);
        check({name, ".depth"}, 64'(bus.depth), 64'd0);
        check({name, ".recording"}, 64'(bus.recording), 64'd0);
        check({name, ".done"}, 64'(bus.done), 64'd0);
        check({name, ".state"}, 64'(state_dbg), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset           = 1'b1;
        bus.record      = 1'b0;
        bus.sampleValid = 1'b0;
        bus.sampleIn    = '0;
        model_depth     = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) step();

        stim = '{100, -200, 1500, 7, 9};
        take("gated_start", 0, 1'b0);

        stim = '{5, -1023, 1000, -7};
        take("abort_armed", 1, 1'b0);

        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(rand_big());
        take("full", 0, 1'b0);

        stim = '{2000, 3, 4, 5};
        take("simul_stop", 0, 1'b1);

        stim = '{-32768, 1};
        take("min_neg", 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            stim.delete();
            n = int'($urandom_range(0, 14));
            for (int i = 0; i < n; i++)
                stim.push_back(($urandom_range(0, 9) < 3) ? rand_small() : rand_big());
            take("random", 2, (n > 0) && ($urandom_range(0, 2) == 0));
        end

        // Reset while a take is writing: the sample driven alongside reset is dropped.
        bus.record = 1'b1;
        step();
        stim = '{3000, -4000, 5000};
        for (int i = 0; i < 3; i++) begin
            bus.sampleValid = 1'b1;
            bus.sampleIn    = DATA_W'(stim[i]);
            push_wr(cyc + 1, i, stim[i]);
            step();
        end
        reset           = 1'b1;
        bus.record      = 1'b0;
        bus.sampleValid = 1'b1;
        bus.sampleIn    = 16'd1234;
        step();
        check_reset_outputs("mid_reset");
        reset           = 1'b0;
        bus.sampleValid = 1'b0;
        model_depth     = '0;
        repeat (3) step();
        check("mid_reset.drained", 64'(exp_wr_q.size() + exp_done_q.size()), 64'd0);

        stim = '{-1500, 22, 33};
        take("after_reset", 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
